// File: rtl/neuron_update_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_update_sequencer
//
// Drives one neuron update per step of a Hopfield-style history network.
// For every step it walks the stored weight vector against the live
// neuron history, one term per clock. It then decides the new neuron state
// from the sign of the sum. Finally it pushes that state into an external
// history shift register.
//
// Ports
//   update_clk   : clock, all state changes on the rising edge
//   rst          : asynchronous, active-high reset (clears weights too)
//   start        : begin a run; only looked at while idle
//   num_steps    : number of neuron updates in the run, latched with start
//   w_we         : weight write enable, honoured only while idle
//   w_addr       : weight index, writes at or beyond N_NEURON are dropped
//   w_data       : signed weight value
//   xalt_packed  : neuron history, state i in bits [2i+1:2i]
//   xin          : new neuron state for the history shift register
//   shift_en     : one-cycle strobe advancing the history by one
//   busy         : high whenever the sequencer is not idle
//   done         : one-cycle pulse at the end of a run
//   step_count   : shift_en pulses issued in the current or last run
//   sum_out      : most recent completed weighted sum
// ---------------------------------------------------------------------------
module neuron_update_sequencer #(
  parameter int N_NEURON = 20,
  parameter int W_WIDTH  = 4
) (
  input  logic                       update_clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 num_steps,
  input  logic                       w_we,
  input  logic [4:0]                 w_addr,
  input  logic signed [W_WIDTH-1:0]  w_data,
  input  logic [2*N_NEURON-1:0]      xalt_packed,
  output logic [1:0]                 xin,
  output logic                       shift_en,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 step_count,
  output logic signed [9:0]          sum_out
);

  // The accumulator is 10 bits wide. With 4-bit weights and states down to
  // -2, the worst-case sums of -280 and +320 still fit.
  localparam int ACC_W = 10;
  localparam int K_W   = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_NEURON - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DECIDE,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [W_WIDTH-1:0] weights [N_NEURON];

  logic [K_W-1:0]          k;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [W_WIDTH-1:0] w_cur;
  logic [1:0]              x_cur;
  logic [7:0]              steps_lat;
  logic [1:0]              xin_q;
  logic signed [ACC_W-1:0] sum_q;
  logic [1:0]              decide_xin;
  logic                    last_term;
  logic                    more_steps;
  logic                    w_addr_ok;

  // Current term operands. The history is read live, so a shift issued in
  // DECIDE is already visible on the first term of the next ACCUM pass.
  assign w_cur     = weights[k];
  assign x_cur     = xalt_packed[2*k +: 2];
  assign w_ext     = {{(ACC_W-W_WIDTH){w_cur[W_WIDTH-1]}}, w_cur};
  assign last_term = (k == K_LAST);
  assign w_addr_ok = (32'(w_addr) < N_NEURON);

  // Compare in 9 bits so that step_count = 255 cannot wrap the test.
  assign more_steps = (({1'b0, step_count} + 9'd1) < {1'b0, steps_lat});

  // A non-negative sum fires the neuron (+1), a negative sum gives -1.
  assign decide_xin = acc[ACC_W-1] ? 2'b11 : 2'b01;

  // Each history state is a 2-bit signed value, so the product reduces to
  // pass, negate, negate-and-double, or zero. No multiplier is needed.
  always_comb begin
    term = '0;
    case (x_cur)
      2'b01:   term = w_ext;
      2'b11:   term = -w_ext;
      2'b10:   term = -(w_ext <<< 1);
      default: term = '0;
    endcase
  end

  // State register.
  always_ff @(posedge update_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A zero-length run goes straight to DONE, so the
  // caller still gets its done pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_steps == 8'd0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (last_term) begin
          state_nxt = DECIDE;
        end
      end
      DECIDE: begin
        state_nxt = more_steps ? ACCUM : DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic. In DECIDE, xin and sum_out show the fresh decision
  // directly. Otherwise they hold the last registered decision.
  always_comb begin
    busy     = (state != IDLE);
    shift_en = (state == DECIDE);
    done     = (state == DONE);
    xin      = xin_q;
    sum_out  = sum_q;
    if (state == DECIDE) begin
      xin     = decide_xin;
      sum_out = acc;
    end
  end

  // Datapath. The accumulator and term index are cleared on every entry
  // to ACCUM, both from IDLE and from DECIDE.
  always_ff @(posedge update_clk or posedge rst) begin
    if (rst) begin
      k          <= '0;
      acc        <= '0;
      steps_lat  <= '0;
      step_count <= '0;
      xin_q      <= 2'b01;
      sum_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            steps_lat  <= num_steps;
            step_count <= '0;
            acc        <= '0;
            k          <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + term;
          if (!last_term) begin
            k <= k + 1'b1;
          end
        end
        DECIDE: begin
          xin_q      <= decide_xin;
          sum_q      <= acc;
          step_count <= step_count + 8'd1;
          acc        <= '0;
          k          <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Weight store. Writes are accepted only while idle, so a run always
  // uses one consistent weight set.
  always_ff @(posedge update_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURON; i++) begin
        weights[i] <= '0;
      end
    end else if (w_we && (state == IDLE) && w_addr_ok) begin
      weights[w_addr] <= w_data;
    end
  end

endmodule

// File: tb/tb_neuron_update_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neuron_update_sequencer
//
// Directed bench for neuron_update_sequencer with N_NEURON=20, W_WIDTH=4.
// Cycle numbering: the clock edge that samples start is cycle 0. Cycle c is
// observed at the falling edge that follows rising edge c-1. This means
// ACCUM k=0 is cycle 1, the first DECIDE is cycle 21 and DONE is cycle 22.
// ---------------------------------------------------------------------------
module tb_neuron_update_sequencer;

  localparam int N = 20;

  logic                update_clk;
  logic                rst;
  logic                start;
  logic [7:0]          num_steps;
  logic                w_we;
  logic [4:0]          w_addr;
  logic signed [3:0]   w_data;
  logic [2*N-1:0]      xalt_packed;
  logic [1:0]          xin;
  logic                shift_en;
  logic                busy;
  logic                done;
  logic [7:0]          step_count;
  logic signed [9:0]   sum_out;

  int checks   = 0;
  int failures = 0;

  // Per-run observations collected by applyStimulus.
  int n_sh;
  int sh_cyc [4];
  int sh_xin [4];
  int sh_sum [4];
  int done_cyc;
  int busy_after;

  neuron_update_sequencer #(
    .N_NEURON (N),
    .W_WIDTH  (4)
  ) dut (
    .update_clk  (update_clk),
    .rst         (rst),
    .start       (start),
    .num_steps   (num_steps),
    .w_we        (w_we),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .xalt_packed (xalt_packed),
    .xin         (xin),
    .shift_en    (shift_en),
    .busy        (busy),
    .done        (done),
    .step_count  (step_count),
    .sum_out     (sum_out)
  );

  initial update_clk = 1'b0;
  always #5 update_clk = ~update_clk;

  // One comparison: counts it, and on a miss reports tag/observed/expected.
  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic writeWeight(input int addr, input logic [3:0] data);
    @(negedge update_clk);
    w_we   = 1'b1;
    w_addr = 5'(addr);
    w_data = data;
    @(negedge update_clk);
    w_we   = 1'b0;
  endtask

  task automatic writeAllWeights(input logic [3:0] data);
    for (int i = 0; i < N; i++) begin
      writeWeight(i, data);
    end
  endtask

  // Starts one run and records every shift_en pulse plus the done cycle.
  // With inject set, a start pulse and a weight write (w[0]=7) go in at
  // cycle 5, while the sequencer is busy.
  task automatic applyStimulus(input logic [7:0] n, input bit inject);
    for (int i = 0; i < 4; i++) begin
      sh_cyc[i] = -1;
      sh_xin[i] = -1;
      sh_sum[i] = -9999;
    end
    n_sh     = 0;
    done_cyc = -1;
    @(negedge update_clk);
    num_steps = n;
    start     = 1'b1;
    @(negedge update_clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
      if (shift_en === 1'b1) begin
        if (n_sh < 4) begin
          sh_cyc[n_sh] = cyc;
          sh_xin[n_sh] = int'(xin);
          sh_sum[n_sh] = int'(sum_out);
        end
        n_sh++;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        if (inject && cyc == 5) begin
          start  = 1'b1;
          w_we   = 1'b1;
          w_addr = 5'd0;
          w_data = 4'sd7;
        end else begin
          start = 1'b0;
          w_we  = 1'b0;
        end
        @(negedge update_clk);
      end
    end
    start = 1'b0;
    w_we  = 1'b0;
    repeat (3) @(negedge update_clk);
    busy_after = int'(busy);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_steps   = 8'd0;
    w_we        = 1'b0;
    w_addr      = 5'd0;
    w_data      = 4'sd0;
    xalt_packed = {N{2'b01}};
    repeat (2) @(negedge update_clk);
    rst = 1'b0;
    @(negedge update_clk);

    // Reset state.
    checkOutput("rst_busy",       busy,       0);
    checkOutput("rst_done",       done,       0);
    checkOutput("rst_shift_en",   shift_en,   0);
    checkOutput("rst_xin",        xin,        1);
    checkOutput("rst_step_count", step_count, 0);
    checkOutput("rst_sum_out",    sum_out,    0);

    // Zero weights, history all +1, one step.
    applyStimulus(8'd1, 1'b0);
    checkOutput("one_shift_count", n_sh,       1);
    checkOutput("one_shift_cyc",   sh_cyc[0],  21);
    checkOutput("one_xin",         sh_xin[0],  1);
    checkOutput("one_sum",         sh_sum[0],  0);
    checkOutput("one_done_cyc",    done_cyc,   22);
    checkOutput("one_step_count",  step_count, 1);
    checkOutput("one_busy_after",  busy_after, 0);

    // w[0] = -1, others 0: sum -1, neuron goes to -1.
    writeWeight(0, 4'hF);
    applyStimulus(8'd1, 1'b0);
    checkOutput("neg_shift_cyc", sh_cyc[0], 21);
    checkOutput("neg_sum",       sh_sum[0], -1);
    checkOutput("neg_xin",       sh_xin[0], 3);
    checkOutput("neg_xin_hold",  xin,       3);

    // Zero-length run: done right away, no shift, step_count cleared.
    applyStimulus(8'd0, 1'b0);
    checkOutput("zero_done_cyc",    done_cyc,   1);
    checkOutput("zero_shift_count", n_sh,       0);
    checkOutput("zero_step_count",  step_count, 0);

    // Three steps with a start and a write injected mid-run. Both must be
    // ignored. Had the write to w[0]=7 landed, the sums would read +7.
    applyStimulus(8'd3, 1'b1);
    checkOutput("three_shift_count", n_sh,       3);
    checkOutput("three_shift_cyc0",  sh_cyc[0],  21);
    checkOutput("three_shift_cyc1",  sh_cyc[1],  42);
    checkOutput("three_shift_cyc2",  sh_cyc[2],  63);
    checkOutput("three_sum0",        sh_sum[0],  -1);
    checkOutput("three_sum2",        sh_sum[2],  -1);
    checkOutput("three_done_cyc",    done_cyc,   64);
    checkOutput("three_step_count",  step_count, 3);
    checkOutput("three_busy_after",  busy_after, 0);

    // Extremes. 20 * (-8 * -2) = +320 and 20 * (7 * -2) = -280.
    xalt_packed = {N{2'b10}};
    writeAllWeights(4'h8);
    applyStimulus(8'd1, 1'b0);
    checkOutput("max_sum", sh_sum[0], 320);
    checkOutput("max_xin", sh_xin[0], 1);
    writeAllWeights(4'h7);
    applyStimulus(8'd1, 1'b0);
    checkOutput("min_sum", sh_sum[0], -280);
    checkOutput("min_xin", sh_xin[0], 3);

    // Reset during ACCUM k=10 (cycle 11 of the run).
    @(negedge update_clk);
    num_steps = 8'd1;
    start     = 1'b1;
    @(negedge update_clk);
    start = 1'b0;
    repeat (10) @(negedge update_clk);
    checkOutput("abort_busy_before", busy, 1);
    checkOutput("abort_xin_before",  xin,  3);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy",       busy,       0);
    checkOutput("abort_xin",        xin,        1);
    checkOutput("abort_step_count", step_count, 0);
    checkOutput("abort_sum_out",    sum_out,    0);
    @(negedge update_clk);
    rst = 1'b0;

    // After the reset the weights must be cleared. With the history at +1,
    // stale weights of 7 would give +140 instead of 0.
    xalt_packed = {N{2'b01}};
    applyStimulus(8'd1, 1'b0);
    checkOutput("post_shift_cyc",   sh_cyc[0],  21);
    checkOutput("post_sum",         sh_sum[0],  0);
    checkOutput("post_xin",         sh_xin[0],  1);
    checkOutput("post_done_cyc",    done_cyc,   22);
    checkOutput("post_step_count",  step_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
